// File: rtl/vending_change_dispenser_pkg.sv
// Shared constants and FSM encoding for the change dispenser.
// Coin order everywhere is index 0 = 100, 1 = 500, 2 = 1000.
package vending_change_dispenser_pkg;

    localparam int unsigned kNumCoinTypes = 3;
    localparam int unsigned kCoin100      = 100;
    localparam int unsigned kCoin500      = 500;
    localparam int unsigned kCoin1000     = 1000;

    localparam logic [kNumCoinTypes-1:0][31:0] kCoinValue = {
        32'(kCoin1000), 32'(kCoin500), 32'(kCoin100)
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_EJECT  = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

endpackage

// File: rtl/vending_change_dispenser_if.sv
// Request/response bundle between the vending core, the coin ejector and the dispenser.
interface vending_change_dispenser_if #(
    parameter int TOTAL_BITS = 32,
    parameter int CNT_BITS   = 8,
    parameter int CNT_OUT    = 10
);
    logic                    i_start;
    logic [TOTAL_BITS-1:0]   i_amount;
    logic [2:0]              i_coin_deposit;
    logic                    i_coin_ack;
    logic [2:0]              o_coin_eject;
    logic                    o_busy;
    logic                    o_done;
    logic                    o_shortfall;
    logic [TOTAL_BITS-1:0]   o_remaining;
    logic [CNT_OUT-1:0]      o_coins_returned;
    logic [3*CNT_BITS-1:0]   o_stock;

    modport master (
        output i_start, i_amount, i_coin_deposit, i_coin_ack,
        input  o_coin_eject, o_busy, o_done, o_shortfall, o_remaining,
               o_coins_returned, o_stock
    );

    modport slave (
        input  i_start, i_amount, i_coin_deposit, i_coin_ack,
        output o_coin_eject, o_busy, o_done, o_shortfall, o_remaining,
               o_coins_returned, o_stock
    );
endinterface

// File: rtl/vending_change_dispenser_coin_stock.sv
// Per-denomination coin-box counter: saturating up/down, simultaneous inc+dec cancels.
module vending_coin_stock #(
    parameter int CNT_BITS   = 8,
    parameter int INIT_COUNT = 20
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                inc,
    input  logic                dec,
    output logic [CNT_BITS-1:0] o_count
);
    logic [CNT_BITS-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && !dec) begin
            if (count_q != '1) count_d = count_q + CNT_BITS'(1);
        end else if (dec && !inc) begin
            if (count_q != '0) count_d = count_q - CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) count_q <= CNT_BITS'(INIT_COUNT);
        else          count_q <= count_d;
    end

    assign o_count = count_q;

endmodule

// File: rtl/vending_change_dispenser.sv
// Greedy change payout: one coin per req/ack handshake, largest affordable in-stock coin first.
module vending_change_dispenser
    import vending_change_dispenser_pkg::*;
#(
    parameter int TOTAL_BITS = 32,
    parameter int CNT_BITS   = 8,
    parameter int INIT_COUNT = 20,
    parameter int CNT_OUT    = 10
) (
    input  logic                      clk,
    input  logic                      reset_n,
    vending_change_dispenser_if.slave bus
);
    state_e                                  state_q, state_d;
    logic [TOTAL_BITS-1:0]                   remaining_q, remaining_d;
    logic [CNT_OUT-1:0]                      count_q, count_d;
    logic                                    shortfall_q, shortfall_d;
    logic                                    done_q, done_d;
    logic                                    busy_q, busy_d;
    logic [kNumCoinTypes-1:0]                eject_q, eject_d;
    logic [kNumCoinTypes-1:0]                dec;
    logic [kNumCoinTypes-1:0]                pick;
    logic [TOTAL_BITS-1:0]                   eject_val;
    logic [kNumCoinTypes-1:0][CNT_BITS-1:0]  stock;

    for (genvar g = 0; g < kNumCoinTypes; g++) begin : g_stock
        vending_coin_stock #(
            .CNT_BITS  (CNT_BITS),
            .INIT_COUNT(INIT_COUNT)
        ) u_stock (
            .clk    (clk),
            .reset_n(reset_n),
            .inc    (bus.i_coin_deposit[g]),
            .dec    (dec[g]),
            .o_count(stock[g])
        );
    end

    // Priority 1000 > 500 > 100 on registered stock; first hit from the top wins.
    always_comb begin
        pick = '0;
        for (int i = kNumCoinTypes - 1; i >= 0; i--) begin
            if (pick == '0 && stock[i] != '0 &&
                remaining_q >= TOTAL_BITS'(kCoinValue[i]))
                pick[i] = 1'b1;
        end
    end

    always_comb begin
        eject_val = '0;
        for (int i = 0; i < kNumCoinTypes; i++) begin
            if (eject_q[i]) eject_val = TOTAL_BITS'(kCoinValue[i]);
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        shortfall_d = shortfall_q;
        eject_d     = eject_q;
        dec         = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    remaining_d = bus.i_amount;
                    count_d     = '0;
                    shortfall_d = 1'b0;
                    state_d     = (bus.i_amount == '0) ? ST_FINISH : ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (pick != '0) begin
                    eject_d = pick;
                    state_d = ST_EJECT;
                end else begin
                    shortfall_d = (remaining_q != '0);
                    state_d     = ST_FINISH;
                end
            end
            ST_EJECT: begin
                if (bus.i_coin_ack) begin
                    remaining_d = remaining_q - eject_val;
                    dec         = eject_q;
                    if (count_q != '1) count_d = count_q + CNT_OUT'(1);
                    eject_d     = '0;
                    state_d     = ST_SELECT;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        // Status flags track the state being entered so they line up with it.
        done_d = (state_d == ST_FINISH);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            count_q     <= '0;
            shortfall_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            eject_q     <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            shortfall_q <= shortfall_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            eject_q     <= eject_d;
        end
    end

    assign bus.o_coin_eject     = eject_q;
    assign bus.o_busy           = busy_q;
    assign bus.o_done           = done_q;
    assign bus.o_shortfall      = shortfall_q;
    assign bus.o_remaining      = remaining_q;
    assign bus.o_coins_returned = count_q;
    assign bus.o_stock          = stock;

endmodule
